// File: rtl/seq_detector_cfg_if.sv
// Bundle of config, serial-data and result signals for seq_detector_cfg.
// The master drives configuration and the bit stream; the slave returns y and match_count.
interface seq_detector_cfg_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               x;
    logic               x_valid;
    logic               y;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, x, x_valid,
        input  y, match_count
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, x, x_valid,
        output y, match_count
    );
endinterface

// File: rtl/seq_detector_cfg.sv
// Run-time configurable serial pattern detector with gapped input, overlap control
// and a saturating match counter.
module seq_detector_cfg #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1011),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seq_detector_cfg_if.slave bus
);
    localparam int               LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               y_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic               enough;
    logic               hit;

    always_comb begin
        hist_nxt = {hist_q[MAX_LEN-2:0], bus.x};
        // Ones in the low len_q positions; len_q == MAX_LEN yields all ones.
        len_mask = ~({MAX_LEN{1'b1}} << len_q);
        fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
        enough   = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
        hit      = bus.x_valid && !bus.cfg_load && enough
                   && (((hist_nxt ^ pat_q) & len_mask) == '0);

        if (bus.cfg_len == '0)
            len_clamped = LEN_W'(1);
        else if (bus.cfg_len > MAX_LEN_L)
            len_clamped = MAX_LEN_L;
        else
            len_clamped = bus.cfg_len;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            y_q <= 1'b0;
            if (bus.cfg_load) begin
                pat_q  <= bus.cfg_pattern;
                len_q  <= len_clamped;
                ovl_q  <= bus.cfg_overlap;
                hist_q <= '0;
                fill_q <= '0;
            end else if (bus.x_valid) begin
                hist_q <= hist_nxt;
                // Non-overlap mode forgets consumed bits by restarting the fill count.
                fill_q <= (hit && !ovl_q) ? '0 : fill_inc;
                y_q    <= hit;
            end

            if (bus.cnt_clr)
                cnt_q <= '0;
            else if (hit && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.y           = y_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_detector_cfg.sv
// Scoreboard bench for seq_detector_cfg: a bit-list reference model predicts y and
// match_count (8-bit and 2-bit instances) per cycle; a monitor compares them.
module tb_seq_detector_cfg;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_detector_cfg_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) bus  ();
    seq_detector_cfg_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) bus2 ();

    seq_detector_cfg #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    seq_detector_cfg #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct {
        bit y;
        int cnt;
        int cnt2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state: the valid bits seen since the last clear, oldest first
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_bits[$];
    int         m_cnt;
    int         m_cnt2;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input logic [7:0] pat, input logic [3:0] len,
                         input bit ovl, input bit clr, input bit xx, input bit xv);
        exp_t e;
        bit   ok;
        int   n;
        @(negedge clk);
        rst = r;
        bus.cfg_load  = ld;  bus2.cfg_load  = ld;
        bus.cfg_pattern = pat; bus2.cfg_pattern = pat;
        bus.cfg_len   = len; bus2.cfg_len   = len;
        bus.cfg_overlap = ovl; bus2.cfg_overlap = ovl;
        bus.cnt_clr   = clr; bus2.cnt_clr   = clr;
        bus.x         = xx;  bus2.x         = xx;
        bus.x_valid   = xv;  bus2.x_valid   = xv;

        e.y = 1'b0;
        if (!r) begin
            m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
            m_bits.delete(); m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (ld) begin
                m_pat = pat;
                m_len = (len == 0) ? 1 : ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len));
                m_ovl = ovl;
                m_bits.delete();
            end else if (xv) begin
                m_bits.push_back(xx);
                if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                n  = m_bits.size();
                ok = (n >= m_len);
                for (int k = 0; k < m_len; k++)
                    if (ok && (m_bits[n-1-k] != m_pat[k])) ok = 1'b0;
                e.y = ok;
                if (ok && !m_ovl) m_bits.delete();
            end
            if (clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (e.y) begin
                m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
                m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end
        end
        e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);
    endtask

    task automatic send(input bit b);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, b, 1'b1);
    endtask

    task automatic gap(input bit b);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, b, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        drive(1'b1, 1'b1, pat, len, ovl, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic send_stream(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("y", int'(bus.y), int'(e.y));
                chk("match_count", int'(bus.match_count), e.cnt);
                chk("match_count_w2", int'(bus2.match_count), e.cnt2);
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        bus.cfg_load = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
        bus.cnt_clr = 0; bus.x = 0; bus.x_valid = 0;
        bus2.cfg_load = 0; bus2.cfg_pattern = 0; bus2.cfg_len = 0; bus2.cfg_overlap = 0;
        bus2.cnt_clr = 0; bus2.x = 0; bus2.x_valid = 0;

        do_reset(); do_reset();
        peek();
        chk("reset_y", int'(bus.y), 0);
        chk("reset_count", int'(bus.match_count), 0);

        // default 1011 overlap
        send_stream(16'b1011011, 7);
        peek(); chk("t1_count", int'(bus.match_count), 2);

        // non-overlap after clearing the counter
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        load(8'b1011, 4'd4, 1'b0);
        send_stream(16'b1011011, 7);
        peek(); chk("t2_count", int'(bus.match_count), 1);

        // gapped stream; x toggles while invalid
        load(8'b1011, 4'd4, 1'b1);
        send(1); send(0);
        gap(1); gap(0); gap(1);
        send(1);
        send(1);
        peek(); chk("t3_y", int'(bus.y), 1);
        chk("t3_count", int'(bus.match_count), 2);

        // length corners
        load(8'b1, 4'd1, 1'b1);
        send_stream(16'b1101, 4);
        peek(); chk("t4_len1_count", int'(bus.match_count), 5);
        load(8'hFF, 4'd8, 1'b1);
        for (int i = 0; i < 10; i++) send(1);
        peek(); chk("t4_len8_count", int'(bus.match_count), 8);
        chk("t5_sat_w2", int'(bus2.match_count), 3);

        // clear coincident with a match
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        peek(); chk("t5_clr_y", int'(bus.y), 1);
        chk("t5_clr_count", int'(bus.match_count), 0);

        // length clamp on load: 0 -> 1, 12 -> 8
        load(8'h01, 4'd0, 1'b1);
        send(1);
        load(8'hFF, 4'd12, 1'b1);
        for (int i = 0; i < 9; i++) send(1);

        // mid-stream reset
        do_reset();
        send_stream(16'b101, 3);
        do_reset();
        send(1);
        peek(); chk("t6_rst_noy", int'(bus.y), 0);
        send_stream(16'b1011, 4);
        peek(); chk("t6_rst_y", int'(bus.y), 1);
        chk("t6_rst_count", int'(bus.match_count), 1);

        // mid-stream reload keeps the count
        send_stream(16'b101, 3);
        load(8'b1011, 4'd4, 1'b1);
        send(1);
        send_stream(16'b1011, 4);
        peek(); chk("t6_load_count", int'(bus.match_count), 2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, ld, clr, xv;
            logic [3:0] len;
            r   = ($urandom_range(0, 99) != 0);
            ld  = ($urandom_range(0, 39) == 0);
            len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
            clr = !ld && ($urandom_range(0, 19) == 0);
            xv  = ($urandom_range(0, 3) != 0);
            drive(r, ld, 8'($urandom), len, 1'($urandom), clr, 1'($urandom), xv);
        end

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
